// File: rtl/result_byte_streamer.sv
// Return-path serializer: buffers result words in a small FIFO and streams them to the
// manta UART bridge as framed bytes (SYNC_BYTE, then each word low byte first).
module result_byte_streamer #(
    parameter int          WORD_WIDTH  = 16,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          FRAME_WORDS = 4,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic                          clk_100mhz,
    input  logic                          sys_rst_n,
    input  logic [WORD_WIDTH-1:0]         word_in,
    input  logic                          word_valid,
    output logic                          word_ready,
    output logic [7:0]                    byte_out,
    output logic                          out_trigger,
    input  logic                          out_ready,
    output logic                          all_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BYTES = WORD_WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WW    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        SEND,
        DONE
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [WORD_WIDTH-1:0] head;
    logic                  push;
    logic                  pop;

    logic [WORD_WIDTH-1:0] sreg;
    logic [BW-1:0]         byte_idx;
    logic [WW-1:0]         word_idx;

    logic                  fire;
    logic                  last_byte;
    logic                  last_word;
    logic                  emit;
    logic [7:0]            emit_byte;
    logic                  start_frame;
    logic                  next_word;
    logic                  shift_byte;
    logic                  frame_done;

    assign word_ready = (fifo_count != CW'(FIFO_DEPTH));
    assign push       = word_valid && word_ready;
    assign head       = mem[rd_ptr];

    // Storage array carries no reset; emptiness is defined purely by the pointers and count.
    always_ff @(posedge clk_100mhz) begin
        if (push) begin
            mem[wr_ptr] <= word_in;
        end
    end

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A byte may only go out when manta is ready and no trigger was issued last cycle,
    // which enforces the two-cycle minimum spacing between strobes.
    assign fire      = out_ready && !out_trigger;
    assign last_byte = (byte_idx == BW'(BYTES - 1));
    assign last_word = (word_idx == WW'(FRAME_WORDS - 1));

    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        emit        = 1'b0;
        emit_byte   = sreg[7:0];
        start_frame = 1'b0;
        next_word   = 1'b0;
        shift_byte  = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_count >= CW'(FRAME_WORDS)) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                if (fire) begin
                    emit        = 1'b1;
                    emit_byte   = SYNC_BYTE;
                    pop         = 1'b1;
                    start_frame = 1'b1;
                    state_next  = SEND;
                end
            end
            SEND: begin
                if (fire) begin
                    emit = 1'b1;
                    if (!last_byte) begin
                        shift_byte = 1'b1;
                    end else if (last_word) begin
                        state_next = DONE;
                    end else begin
                        pop       = 1'b1;
                        next_word = 1'b1;
                    end
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_out      <= '0;
            out_trigger   <= 1'b0;
            all_out_ready <= 1'b0;
            sreg          <= '0;
            byte_idx      <= '0;
            word_idx      <= '0;
        end else begin
            out_trigger   <= emit;
            all_out_ready <= frame_done;
            if (emit) begin
                byte_out <= emit_byte;
            end
            if (start_frame) begin
                sreg     <= head;
                byte_idx <= '0;
                word_idx <= '0;
            end else if (next_word) begin
                sreg     <= head;
                byte_idx <= '0;
                word_idx <= word_idx + WW'(1);
            end else if (shift_byte) begin
                sreg     <= sreg >> 8;
                byte_idx <= byte_idx + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_result_byte_streamer.sv
// Scoreboard bench for result_byte_streamer: stimulus queues hand-computed frame bytes,
// a negedge monitor pops and compares every triggered byte and frame-done strobe.
module tb_result_byte_streamer;

    typedef struct {
        logic [7:0] b;
        bit         last;
        bit         pop;
    } exp_t;

    logic        clk_100mhz = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic [15:0] word_in    = '0;
    logic        word_valid = 1'b0;
    logic        out_ready  = 1'b0;
    logic        word_ready;
    logic [7:0]  byte_out;
    logic        out_trigger;
    logic        all_out_ready;
    logic [3:0]  fifo_count;

    exp_t exp_q[$];
    int   assertions = 0;
    int   failures   = 0;
    int   trig_count = 0;
    int   done_count = 0;
    int   both_count = 0;

    result_byte_streamer dut (
        .clk_100mhz    (clk_100mhz),
        .sys_rst_n     (sys_rst_n),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .byte_out      (byte_out),
        .out_trigger   (out_trigger),
        .out_ready     (out_ready),
        .all_out_ready (all_out_ready),
        .fifo_count    (fifo_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Frame bytes are given first-byte-in-MSB; pop marks bytes whose trigger edge also pops a word.
    task automatic expectFrame(input logic [71:0] f);
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            e.b    = f[71-8*i -: 8];
            e.last = (i == 8);
            e.pop  = (i == 0) || (i == 2) || (i == 4) || (i == 6);
            exp_q.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] w);
        int n = 0;
        while (!word_ready && n < 200) begin
            @(posedge clk_100mhz); #1;
            n++;
        end
        if (n >= 200) checkOutput("word_ready_timeout", 0, 1);
        word_in    = w;
        word_valid = 1'b1;
        @(posedge clk_100mhz); #1;
        word_valid = 1'b0;
    endtask

    task automatic waitFor(input string name, input int trig_target, input int done_target, input int budget);
        int n = 0;
        while ((trig_count < trig_target || done_count < done_target) && n < budget) begin
            @(posedge clk_100mhz); #1;
            n++;
        end
        checkOutput({name, "_complete"}, 64'(trig_count >= trig_target && done_count >= done_target), 1);
    endtask

    // Monitor: compares bytes, strobe spacing, frame-done timing and a push/pop count model.
    initial begin
        exp_t e;
        bit   prev_trig    = 0;
        bit   last_prev    = 0;
        bit   pending_push = 0;
        bit   pop_now;
        bit   last_now;
        int   model_count  = 0;
        int   new_model;
        forever begin
            @(negedge clk_100mhz);
            if (!sys_rst_n) begin
                prev_trig    = 0;
                last_prev    = 0;
                pending_push = 0;
                model_count  = 0;
                continue;
            end
            pop_now  = 0;
            last_now = 0;
            if (out_trigger) begin
                trig_count++;
                checkOutput("trigger_spacing", 64'(prev_trig), 0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_byte", {56'h0, byte_out}, 64'h100);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("byte_out", {56'h0, byte_out}, {56'h0, e.b});
                    pop_now  = e.pop;
                    last_now = e.last;
                end
            end
            if (all_out_ready || last_prev) begin
                checkOutput("all_out_ready", 64'(all_out_ready), 64'(last_prev));
            end
            if (all_out_ready) done_count++;
            new_model = model_count + int'(pending_push) - int'(pop_now);
            if (pending_push && pop_now) begin
                both_count++;
                checkOutput("push_pop_unchanged", {60'h0, fifo_count}, 64'(model_count));
            end else if (pending_push || pop_now) begin
                checkOutput("fifo_count_model", {60'h0, fifo_count}, 64'(new_model));
            end
            model_count  = new_model;
            prev_trig    = out_trigger;
            last_prev    = out_trigger && last_now;
            pending_push = word_valid && word_ready;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_t;
        int base_d;
        int base_b;
        int accepted;
        bit acc;

        out_ready = 1'b1;
        repeat (3) @(posedge clk_100mhz);
        #1;
        checkOutput("reset_fifo_count", {60'h0, fifo_count}, 0);
        checkOutput("reset_word_ready", 64'(word_ready), 1);
        checkOutput("reset_byte_out", {56'h0, byte_out}, 0);
        checkOutput("reset_out_trigger", 64'(out_trigger), 0);
        checkOutput("reset_all_out_ready", 64'(all_out_ready), 0);
        #1 sys_rst_n = 1'b1;
        @(posedge clk_100mhz); #1;

        $display("[TB] basic frame");
        base_t = trig_count; base_d = done_count;
        expectFrame(72'hA5_34_12_CD_AB_01_00_00_FF);
        applyStimulus(16'h1234);
        applyStimulus(16'hABCD);
        applyStimulus(16'h0001);
        applyStimulus(16'hFF00);
        waitFor("frame1", base_t + 9, base_d + 1, 100);
        repeat (2) @(posedge clk_100mhz); #1;
        checkOutput("frame1_triggers", 64'(trig_count), 64'(base_t + 9));
        checkOutput("frame1_done_pulses", 64'(done_count), 64'(base_d + 1));
        checkOutput("frame1_fifo_empty", {60'h0, fifo_count}, 0);

        $display("[TB] short frame waits");
        base_t = trig_count; base_d = done_count;
        expectFrame(72'hA5_02_01_04_03_06_05_08_07);
        applyStimulus(16'h0102);
        applyStimulus(16'h0304);
        applyStimulus(16'h0506);
        repeat (100) @(posedge clk_100mhz); #1;
        checkOutput("short_no_trigger", 64'(trig_count), 64'(base_t));
        checkOutput("short_fifo_count", {60'h0, fifo_count}, 3);
        applyStimulus(16'h0708);
        checkOutput("fourth_fifo_count", {60'h0, fifo_count}, 4);
        acc = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_100mhz); #1;
            if (out_trigger) acc = 1;
            if (acc) break;
        end
        checkOutput("sync_latency", 64'(acc), 1);
        checkOutput("sync_latency_byte", {56'h0, byte_out}, 64'hA5);
        waitFor("frame2", base_t + 9, base_d + 1, 100);

        $display("[TB] fill with out_ready low");
        @(posedge clk_100mhz); #1;
        out_ready = 1'b0;
        base_t = trig_count; base_d = done_count;
        expectFrame(72'hA5_00_C0_01_C0_02_C0_03_C0);
        expectFrame(72'hA5_04_C0_05_C0_06_C0_07_C0);
        accepted = 0;
        for (int i = 0; i < 12; i++) begin
            word_in    = 16'hC000 + 16'(accepted);
            word_valid = 1'b1;
            acc        = word_ready;
            @(posedge clk_100mhz); #1;
            if (acc) accepted++;
        end
        word_valid = 1'b0;
        checkOutput("fill_accepted", 64'(accepted), 8);
        checkOutput("fill_fifo_count", {60'h0, fifo_count}, 8);
        checkOutput("fill_word_ready", 64'(word_ready), 0);
        checkOutput("fill_no_trigger", 64'(trig_count), 64'(base_t));
        out_ready = 1'b1;
        waitFor("fill_frames", base_t + 18, base_d + 2, 200);

        $display("[TB] mid-frame stall");
        @(posedge clk_100mhz); #1;
        base_t = trig_count; base_d = done_count;
        expectFrame(72'hA5_0B_0A_0D_0C_0F_0E_20_10);
        applyStimulus(16'h0A0B);
        applyStimulus(16'h0C0D);
        applyStimulus(16'h0E0F);
        applyStimulus(16'h1020);
        waitFor("stall_first3", base_t + 3, base_d, 50);
        out_ready = 1'b0;
        repeat (20) @(posedge clk_100mhz); #1;
        checkOutput("stall_no_trigger", 64'(trig_count), 64'(base_t + 3));
        out_ready = 1'b1;
        waitFor("stall_resume", base_t + 9, base_d + 1, 100);

        $display("[TB] async reset mid-frame");
        @(posedge clk_100mhz); #1;
        base_t = trig_count; base_d = done_count;
        expectFrame(72'hA5_57_13_68_24_DF_9B_E0_AC);
        applyStimulus(16'h1357);
        applyStimulus(16'h2468);
        applyStimulus(16'h9BDF);
        applyStimulus(16'hACE0);
        waitFor("reset_prefix", base_t + 4, base_d, 50);
        @(posedge clk_100mhz); #2;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("rst_fifo_count", {60'h0, fifo_count}, 0);
        checkOutput("rst_out_trigger", 64'(out_trigger), 0);
        checkOutput("rst_byte_out", {56'h0, byte_out}, 0);
        checkOutput("rst_word_ready", 64'(word_ready), 1);
        exp_q.delete();
        repeat (2) @(posedge clk_100mhz); #2;
        sys_rst_n = 1'b1;
        repeat (3) @(posedge clk_100mhz); #1;
        checkOutput("rst_no_done", 64'(done_count), 64'(base_d));
        base_t = trig_count;
        expectFrame(72'hA5_34_12_CD_AB_01_00_00_FF);
        applyStimulus(16'h1234);
        applyStimulus(16'hABCD);
        applyStimulus(16'h0001);
        applyStimulus(16'hFF00);
        waitFor("post_reset_frame", base_t + 9, base_d + 1, 100);

        $display("[TB] back-to-back frames");
        @(posedge clk_100mhz); #1;
        base_t = trig_count; base_d = done_count; base_b = both_count;
        expectFrame(72'hA5_11_00_33_22_55_44_77_66);
        expectFrame(72'hA5_99_88_BB_AA_DD_CC_FF_EE);
        applyStimulus(16'h0011);
        applyStimulus(16'h2233);
        applyStimulus(16'h4455);
        applyStimulus(16'h6677);
        applyStimulus(16'h8899);
        applyStimulus(16'hAABB);
        applyStimulus(16'hCCDD);
        applyStimulus(16'hEEFF);
        waitFor("b2b_frames", base_t + 18, base_d + 2, 200);
        repeat (3) @(posedge clk_100mhz); #1;
        checkOutput("b2b_triggers", 64'(trig_count), 64'(base_t + 18));
        checkOutput("b2b_done_pulses", 64'(done_count), 64'(base_d + 2));
        checkOutput("b2b_push_pop_seen", 64'(both_count > base_b), 1);
        checkOutput("b2b_fifo_empty", {60'h0, fifo_count}, 0);
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
